// File: rtl/sha_core_arbiter.sv
// -----------------------------------------------------------------------------
// sha_core_arbiter
//
// Round-robin arbiter/sequencer sharing one SHA-256 compression core among
// NUM_REQ requesters. The arbiter holds one job at a time:
//   1. It accepts a block and an input hash from the granted requester.
//   2. It pulses the core start for one cycle.
//   3. It waits for done and returns the result tagged with the requester ID.
//
// Optional feature macro: SHA_ARB_TIMEOUT_EN
//   When defined, a job is aborted after TIMEOUT WAIT cycles without done.
//   The aborted job is reported with rsp_error=1 and rsp_hout=0.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   i_req_valid        per-requester job request
//   o_req_ready        one-hot accept strobe (combinational, IDLE only)
//   i_req_block        requester i at [i*512 +: 512], word 0 in the MS bits
//   i_req_hin          requester i at [i*256 +: 256], H0 in the MS bits
//   o_core_start       one-cycle start pulse to the core
//   o_core_message     latched block, held until the next accept
//   o_core_hin         latched input hash, held until the next accept
//   i_core_done        core completion, honoured only in WAIT
//   i_core_hout        core result
//   o_rsp_valid        result available
//   i_rsp_ready        consumer accepts the result
//   o_rsp_id           requester owning the result
//   o_rsp_hout         hash result
//   o_rsp_error        job aborted by timeout
//   o_busy             arbiter not idle
// -----------------------------------------------------------------------------
module sha_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [NUM_REQ*512-1:0] i_req_block,
    input  logic [NUM_REQ*256-1:0] i_req_hin,
    output logic                   o_core_start,
    output logic [511:0]           o_core_message,
    output logic [255:0]           o_core_hin,
    input  logic                   i_core_done,
    input  logic [255:0]           i_core_hout,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [IDW-1:0]         o_rsp_id,
    output logic [255:0]           o_rsp_hout,
    output logic                   o_rsp_error,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   w_grant;
    logic [IDW:0]     w_sum;
    logic             w_found;
    logic             w_accept;
    logic             w_timeout;
    logic [NUM_REQ-1:0] w_ready;
    logic [511:0]     r_msg;
    logic [511:0]     w_blk;
    logic [255:0]     r_hin;
    logic [255:0]     w_hin;
    logic [255:0]     r_rsp_hout;
    logic             r_rsp_valid;

    // Round-robin search: the lowest offset from r_rr_ptr with a valid request wins.
    // Scanning from the highest offset down lets the last hit be the winner.
    always_comb begin
        w_found = 1'b0;
        w_grant = {IDW{1'b0}};
        w_sum   = {(IDW+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            if (i_req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_sum[IDW-1:0];
            end else begin
                w_found = w_found;
            end
        end
        // Keep req_ready at its reset value while reset is asserted.
        w_found = w_found & reset_n;
    end

    assign w_accept = (r_state == ST_IDLE) && w_found;

    // Select the winning lane's data and build the one-hot accept strobe.
    always_comb begin
        w_blk   = 512'd0;
        w_hin   = 256'd0;
        w_ready = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept && (w_grant == IDW'(i))) begin
                w_ready[i] = 1'b1;
                w_blk      = i_req_block[i*512 +: 512];
                w_hin      = i_req_hin[i*256 +: 256];
            end else begin
                w_ready[i] = 1'b0;
            end
        end
    end

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_rsp_error;

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    // WAIT-cycle counter, cleared while in ISSUE so it starts at zero on WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Error flag: cleared on a real completion, set on an abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_error <= 1'b0;
        end else if ((r_state == ST_WAIT) && i_core_done) begin
            r_rsp_error <= 1'b0;
        end else if ((r_state == ST_WAIT) && w_timeout) begin
            r_rsp_error <= 1'b1;
        end else begin
            r_rsp_error <= r_rsp_error;
        end
    end

    assign o_rsp_error = r_rsp_error;
`else
    assign w_timeout   = 1'b0;
    assign o_rsp_error = 1'b0;
`endif

    // Next-state logic; core_done counts only in WAIT, so a stale level-high done is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next = ST_ISSUE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_core_done || w_timeout) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Job latch: core inputs and owner ID change only on an accept cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_msg <= 512'd0;
            r_hin <= 256'd0;
            r_id  <= {IDW{1'b0}};
        end else if (w_accept) begin
            r_msg <= w_blk;
            r_hin <= w_hin;
            r_id  <= w_grant;
        end
    end

    // Response capture, response handshake, and pointer advance on a completed response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hout  <= 256'd0;
            r_rr_ptr    <= {IDW{1'b0}};
        end else if ((r_state == ST_WAIT) && i_core_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hout  <= i_core_hout;
        end else if ((r_state == ST_WAIT) && w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hout  <= 256'd0;
        end else if ((r_state == ST_RESP) && i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= (r_id == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : (r_id + IDW'(1));
        end
    end

    assign o_req_ready    = w_ready;
    assign o_core_start   = (r_state == ST_ISSUE);
    assign o_core_message = r_msg;
    assign o_core_hin     = r_hin;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_id       = r_id;
    assign o_rsp_hout     = r_rsp_hout;
    assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sha_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sha_core_arbiter
//
// Scoreboard bench for sha_core_arbiter with a behavioural stub core.
// - The stub returns the SHA-256("abc") digest for the padded "abc" block with
//   the standard IV.
// - For any other input it returns a simple additive fold, which the bench
//   models independently.
// - Expected responses are queued when a job is issued.
// - A negedge monitor pops an entry on each rsp handshake and compares it.
// -----------------------------------------------------------------------------
module tb_sha_core_arbiter;
    localparam int N  = 4;
    localparam int TO = 10;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIGEST  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*512-1:0] req_block;
    logic [N*256-1:0] req_hin;
    logic             core_start;
    logic [511:0]     core_message;
    logic [255:0]     core_hin;
    logic             core_done;
    logic [255:0]     core_hout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [255:0]     rsp_hout;
    logic             rsp_error;
    logic             busy;

    always #5 clk = ~clk;

    sha_core_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_block(req_block), .i_req_hin(req_hin),
        .o_core_start(core_start), .o_core_message(core_message), .o_core_hin(core_hin),
        .i_core_done(core_done), .i_core_hout(core_hout),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_hout(rsp_hout), .o_rsp_error(rsp_error), .o_busy(busy)
    );

    typedef struct {
        logic [1:0]   id;
        logic [255:0] hout;
        logic         err;
        logic [511:0] msg;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int resp_cnt = 0;
    int grants = 0;
    int last_grant = 0;
    int start_w = 0;
    int wait_cyc = 0;

    function automatic logic [255:0] model(input logic [511:0] m, input logic [255:0] h);
        if (m == ABC_BLK && h == IV) return DIGEST;
        return m[511:256] + m[255:0] + h;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Stub core: done rises stub_lat cycles after start and stays high 1+stub_extra cycles.
    int       stub_lat = 5;
    int       stub_extra = 0;
    bit       stub_never = 1'b0;
    int       s_cnt;
    int       s_hold;
    bit       s_busy;
    logic [255:0] s_hout;
    assign core_done = (s_hold != 0);
    assign core_hout = s_hout;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_cnt <= 0; s_hold <= 0; s_busy <= 1'b0; s_hout <= 256'd0;
        end else begin
            if (s_hold != 0) s_hold <= s_hold - 1;
            if (core_start) begin
                s_busy <= 1'b1;
                s_cnt  <= stub_lat - 1;
                s_hout <= model(core_message, core_hin);
            end else if (s_busy) begin
                if (s_cnt == 0) begin
                    s_busy <= 1'b0;
                    if (!stub_never) s_hold <= 1 + stub_extra;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    // Monitor: responses, grants, start pulse width, WAIT cycle count.
    always @(negedge clk) begin
        if (!reset_n) begin
            start_w = 0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got id %0d with no job pending, required none", rsp_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_hout", rsp_hout, e.hout);
                    check("rsp_error", rsp_error, e.err);
                    check("core_message_held", core_message, e.msg);
                end
            end
            if (|req_ready) begin
                grants++;
                for (int i = 0; i < N; i++) if (req_ready[i]) last_grant = i;
            end
            if (core_start) begin
                start_w++;
            end else if (start_w != 0) begin
                check("core_start_width", start_w, 1);
                start_w = 0;
            end
            if (busy && !core_start && !rsp_valid) wait_cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int lane, input logic err);
        exp_t e;
        e.id   = 2'(lane);
        e.msg  = req_block[lane*512 +: 512];
        e.err  = err;
        e.hout = err ? 256'd0 : model(req_block[lane*512 +: 512], req_hin[lane*256 +: 256]);
        sb.push_back(e);
    endtask

    task automatic wait_grant(output int lane);
        int g0;
        int c;
        g0 = grants;
        c = 0;
        while (grants == g0 && c < 200) begin
            tick(1);
            c++;
        end
        check("grant_seen", (grants != g0), 1'b1);
        lane = last_grant;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        check("responses_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_message"}, core_message, 0);
        check({tag, "_core_hin"}, core_hin, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_hout"}, rsp_hout, 0);
        check({tag, "_rsp_error"}, rsp_error, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    initial begin
        int l;
        logic [255:0] h_hold;
        logic [1:0]   id_hold;
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_block[i*512 +: 512] = {4{32'hC0DE_0000 + 32'(i), 32'h0BAD_F00D,
                                          32'h1357_9BDF + 32'(i*7), 32'hFEED_0000}};
            req_hin[i*256 +: 256]   = {8{32'h5EED_0000 + 32'(i)}};
        end
        tick(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick(2);

        // All lanes valid for 8 jobs: strict 0,1,2,3 rotation.
        for (int j = 0; j < 8; j++) push_exp(j % N, 1'b0);
        req_valid = 4'hF;
        for (int j = 0; j < 8; j++) begin
            wait_grant(l);
            check("rr_order", l, j % N);
            check("start_after_accept", core_start, 1'b1);
            if (j == 7) req_valid = 4'h0;
        end
        drain(300);

        // Padded "abc" with the standard IV on lane 2.
        req_block[2*512 +: 512] = ABC_BLK;
        req_hin[2*256 +: 256]   = IV;
        push_exp(2, 1'b0);
        req_valid[2] = 1'b1;
        wait_grant(l);
        check("abc_grant", l, 2);
        req_valid[2] = 1'b0;
        drain(100);

        // Back-pressure: rr_ptr is 3, lanes 0 and 1 request, consumer stalls.
        rsp_ready = 1'b0;
        push_exp(0, 1'b0);
        push_exp(1, 1'b0);
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        wait_grant(l);
        check("bp_grant", l, 0);
        req_valid[0] = 1'b0;
        for (int c = 0; c < 100 && !rsp_valid; c++) tick(1);
        check("bp_rsp_arrives", rsp_valid, 1'b1);
        h_hold  = rsp_hout;
        id_hold = rsp_id;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_id", rsp_id, id_hold);
            check("bp_rsp_hout", rsp_hout, h_hold);
            check("bp_req_ready", req_ready, 0);
            check("bp_core_start", core_start, 1'b0);
        end
        rsp_ready = 1'b1;
        wait_grant(l);
        check("bp_next_grant", l, 1);
        req_valid[1] = 1'b0;
        drain(100);

        // done held 3 extra cycles: one response per job, stale done ignored in ISSUE.
        stub_extra = 3;
        push_exp(2, 1'b0);
        push_exp(3, 1'b0);
        begin
            int rc0;
            rc0 = resp_cnt;
            req_valid[2] = 1'b1;
            req_valid[3] = 1'b1;
            wait_grant(l);
            check("hold_grant_a", l, 2);
            req_valid[2] = 1'b0;
            wait_grant(l);
            check("hold_grant_b", l, 3);
            req_valid[3] = 1'b0;
            drain(100);
            tick(10);
            check("one_rsp_per_job", resp_cnt - rc0, 2);
        end
        stub_extra = 0;

        // Reset in WAIT: move rr_ptr to 2 first, so lane 3 would win without the reset.
        push_exp(1, 1'b0);
        req_valid[1] = 1'b1;
        wait_grant(l);
        req_valid[1] = 1'b0;
        drain(100);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        wait_grant(l);
        check("pre_reset_grant", l, 3);
        req_valid[3] = 1'b0;
        tick(1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick(1);
        push_exp(0, 1'b0);
        push_exp(3, 1'b0);
        req_valid[3] = 1'b1;
        reset_n = 1'b1;
        wait_grant(l);
        check("post_reset_grant", l, 0);
        req_valid[0] = 1'b0;
        wait_grant(l);
        check("post_reset_next", l, 3);
        req_valid[3] = 1'b0;
        drain(100);

`ifdef SHA_ARB_TIMEOUT_EN
        // Core never completes: abort after exactly TO WAIT cycles.
        stub_never = 1'b1;
        push_exp(3, 1'b1);
        req_valid[3] = 1'b1;
        wait_grant(l);
        req_valid[3] = 1'b0;
        wait_cyc = 0;
        drain(100);
        check("timeout_wait_cycles", wait_cyc, TO);
        stub_never = 1'b0;
`endif

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
